// File: rtl/pwm_led_driver_if.sv
// Chip-select/write/read slave bus shared by the LED data register and the PWM driver.
// The bus master drives the strobes, address and write data; the slave returns registered read data.
interface pwm_led_driver_if;
   logic        iChip_select_n;
   logic        iWrite_n;
   logic        iRead_n;
   logic [1:0]  iAddress;
   logic [31:0] iWritedata;
   logic [31:0] oReaddata;

   modport master (
      output iChip_select_n, iWrite_n, iRead_n, iAddress, iWritedata,
      input  oReaddata
   );

   modport slave (
      input  iChip_select_n, iWrite_n, iRead_n, iAddress, iWritedata,
      output oReaddata
   );
endinterface

// File: rtl/pwm_led_driver.sv
// Memory-mapped PWM generator for the red LED.
// PERIOD/DUTY are double-buffered and only reach the counter at a period boundary.
module pwm_led_driver #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic            iClk,
   input  logic            iReset,
   pwm_led_driver_if.slave bus,
   output logic            oPwm,
   output logic            oPeriod_done
);
   typedef logic [CNT_WIDTH-1:0] cnt_t;
   typedef enum logic [1:0] {
      ADDR_CTRL   = 2'd0,
      ADDR_PERIOD = 2'd1,
      ADDR_DUTY   = 2'd2,
      ADDR_STATUS = 2'd3
   } addr_e;

   logic        en_q, en_d, inv_q, inv_d;
   cnt_t        period_q, period_d, duty_q, duty_d;
   cnt_t        period_act_q, period_act_d, duty_act_q, duty_act_d;
   cnt_t        cnt_q, cnt_d;
   logic        pwm_q, pwm_d, done_q, done_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] status;
   logic        wr_en, rd_en;
   addr_e       addr;

   assign wr_en = !bus.iChip_select_n && !bus.iWrite_n;
   assign rd_en = !bus.iChip_select_n && !bus.iRead_n;
   assign addr  = addr_e'(bus.iAddress);

   // EN occupies bit 31 even when the counter is a full 32 bits wide.
   always_comb begin
      status     = 32'(cnt_q);
      status[31] = en_q;
   end

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      en_d     = en_q;
      inv_d    = inv_q;
      period_d = period_q;
      duty_d   = duty_q;
      if (wr_en) begin
         case (addr)
            ADDR_CTRL: begin
               en_d  = bus.iWritedata[0];
               inv_d = bus.iWritedata[1];
            end
            ADDR_PERIOD: period_d = bus.iWritedata[CNT_WIDTH-1:0];
            ADDR_DUTY:   duty_d   = bus.iWritedata[CNT_WIDTH-1:0];
            default:     ;
         endcase
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         case (addr)
            ADDR_CTRL:   rdata_d = {30'd0, inv_q, en_q};
            ADDR_PERIOD: rdata_d = 32'(period_q);
            ADDR_DUTY:   rdata_d = 32'(duty_q);
            default:     rdata_d = status;
         endcase
      end
   end

   // With no period in progress (disabled or zero period) the active copies follow the pending ones.
   always_comb begin
      cnt_d        = cnt_q;
      period_act_d = period_act_q;
      duty_act_d   = duty_act_q;
      done_d       = 1'b0;
      if (!en_q || period_act_q == '0) begin
         cnt_d        = '0;
         period_act_d = period_q;
         duty_act_d   = duty_q;
      end else if (cnt_q == period_act_q - cnt_t'(1)) begin
         cnt_d        = '0;
         period_act_d = period_q;
         duty_act_d   = duty_q;
         done_d       = 1'b1;
      end else begin
         cnt_d = cnt_q + cnt_t'(1);
      end
   end

   assign pwm_d = en_q && (period_act_q != '0) && (cnt_q < duty_act_q);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         en_q         <= 1'b0;
         inv_q        <= 1'b0;
         period_q     <= '0;
         duty_q       <= '0;
         period_act_q <= '0;
         duty_act_q   <= '0;
         cnt_q        <= '0;
         pwm_q        <= 1'b0;
         done_q       <= 1'b0;
         rdata_q      <= '0;
      end else begin
         en_q         <= en_d;
         inv_q        <= inv_d;
         period_q     <= period_d;
         duty_q       <= duty_d;
         period_act_q <= period_act_d;
         duty_act_q   <= duty_act_d;
         cnt_q        <= cnt_d;
         pwm_q        <= pwm_d;
         done_q       <= done_d;
         rdata_q      <= rdata_d;
      end
   end

   assign oPwm          = pwm_q ^ inv_q;
   assign oPeriod_done  = done_q;
   assign bus.oReaddata = rdata_q;
endmodule

// File: tb/tb_pwm_led_driver.sv
// Scoreboarded bench for pwm_led_driver: stimulus queues per-cycle expectations,
// a negedge monitor compares whatever is due in the current cycle.
module tb_pwm_led_driver;
   localparam int CNT_WIDTH = 16;

   typedef enum logic [1:0] {K_PWM, K_DONE, K_RDATA} kind_e;
   typedef struct {
      int          cyc;
      kind_e       kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic iClk   = 1'b0;
   logic iReset = 1'b1;
   logic oPwm, oPeriod_done;

   pwm_led_driver_if bus ();

   pwm_led_driver #(.CNT_WIDTH(CNT_WIDTH)) dut (
      .iClk         (iClk),
      .iReset       (iReset),
      .bus          (bus),
      .oPwm         (oPwm),
      .oPeriod_done (oPeriod_done)
   );

   always #5 iClk = ~iClk;

   int   cyc = 0;
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   mon_i;

   always @(posedge iClk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void expect_at(input int c, input kind_e k, input logic [31:0] v,
                                     input string nm);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endfunction

   // Monitor: compare every expectation due this cycle, flag any that were skipped.
   always @(negedge iClk) begin
      mon_i = 0;
      while (mon_i < sb.size()) begin
         if (sb[mon_i].cyc == cyc) begin
            case (sb[mon_i].kind)
               K_PWM:   check(sb[mon_i].name, 32'(oPwm), sb[mon_i].val);
               K_DONE:  check(sb[mon_i].name, 32'(oPeriod_done), sb[mon_i].val);
               default: check(sb[mon_i].name, bus.oReaddata, sb[mon_i].val);
            endcase
            sb.delete(mon_i);
         end else if (sb[mon_i].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never sampled, expected 0x%08h at cycle %0d",
                     sb[mon_i].name, sb[mon_i].val, sb[mon_i].cyc);
            sb.delete(mon_i);
         end else begin
            mon_i++;
         end
      end
   end

   task automatic bus_idle();
      bus.iChip_select_n = 1'b1;
      bus.iWrite_n       = 1'b1;
      bus.iRead_n        = 1'b1;
      bus.iAddress       = 2'd0;
      bus.iWritedata     = 32'd0;
   endtask

   // Bus tasks start 1ns after an edge; on return cyc is the edge that performed the access.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.iChip_select_n = 1'b0;
      bus.iWrite_n       = 1'b0;
      bus.iAddress       = a;
      bus.iWritedata     = d;
      @(posedge iClk); #1;
      bus_idle();
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
      bus.iChip_select_n = 1'b0;
      bus.iRead_n        = 1'b0;
      bus.iAddress       = a;
      @(posedge iClk); #1;
      expect_at(cyc, K_RDATA, e, nm);
      bus_idle();
   endtask

   task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e,
                     input string nm);
      bus.iChip_select_n = 1'b0;
      bus.iWrite_n       = 1'b0;
      bus.iRead_n        = 1'b0;
      bus.iAddress       = a;
      bus.iWritedata     = d;
      @(posedge iClk); #1;
      expect_at(cyc, K_RDATA, e, nm);
      bus_idle();
   endtask

   task automatic idle_until(input int c);
      while (cyc < c) begin
         @(posedge iClk); #1;
      end
   endtask

   // Reprogram from a disabled state, enable with ctrl, and expect n cycles of waveform.
   task automatic run_case(input int p, input int d, input logic [1:0] ctrl, input int n,
                           input string nm);
      int e;
      logic raw, done;
      wr(2'd0, 32'd0);
      wr(2'd1, 32'(p));
      wr(2'd2, 32'(d));
      wr(2'd0, 32'(ctrl));
      e = cyc;
      for (int k = 1; k <= n; k++) begin
         raw  = 1'b0;
         done = 1'b0;
         if (ctrl[0] && p != 0) begin
            raw  = ((k - 1) % p) < d;
            done = (k % p) == 0;
         end
         expect_at(e + k, K_PWM, 32'(raw ^ ctrl[1]), {nm, "_pwm"});
         expect_at(e + k, K_DONE, 32'(done), {nm, "_done"});
      end
      idle_until(e + n);
   endtask

   initial begin
      int e;
      int duty;
      bus_idle();

      // Reset values
      repeat (3) @(posedge iClk);
      #1 iReset = 1'b0;
      expect_at(cyc, K_PWM, 32'd0, "reset_pwm");
      expect_at(cyc, K_DONE, 32'd0, "reset_done");
      expect_at(cyc, K_RDATA, 32'd0, "reset_rdata");
      rd(2'd3, 32'd0, "reset_status");
      rd(2'd0, 32'd0, "reset_ctrl");
      rd(2'd1, 32'd0, "reset_period");
      rd(2'd2, 32'd0, "reset_duty");

      // Register width and reserved bits
      wr(2'd1, 32'h1234_ABCD);
      rd(2'd1, 32'h0000_ABCD, "period_trunc");
      wr(2'd0, 32'h0000_00FF);
      rd(2'd0, 32'h0000_0003, "ctrl_bits");
      wr(2'd0, 32'd0);
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd3, 32'd0, "status_ro");

      // 10/3 waveform, mid-period DUTY=7, then DUTY=2 written on a wrap edge
      wr(2'd1, 32'd10);
      wr(2'd2, 32'd3);
      wr(2'd0, 32'd1);
      e = cyc;
      for (int k = 1; k <= 40; k++) begin
         duty = (k <= 10) ? 3 : (k <= 30) ? 7 : 2;
         expect_at(e + k, K_PWM, 32'(((k - 1) % 10) < duty), "dbuf_pwm");
         expect_at(e + k, K_DONE, 32'((k % 10) == 0), "dbuf_done");
      end
      idle_until(e + 3);
      wr(2'd2, 32'd7);
      idle_until(e + 19);
      wr(2'd2, 32'd2);
      idle_until(e + 44);
      rd(2'd3, 32'h8000_0004, "status_run");
      rd(2'd2, 32'd2, "duty_pending");
      rw(2'd2, 32'd5, 32'd2, "rw_old");
      rd(2'd2, 32'd5, "rw_new");

      // Duty and period boundaries
      run_case(10, 0, 2'b01, 20, "duty0");
      run_case(10, 10, 2'b01, 20, "duty10");
      run_case(10, 15, 2'b01, 20, "duty15");
      run_case(0, 3, 2'b01, 20, "period0");

      // Inversion
      run_case(4, 1, 2'b11, 12, "inv");
      run_case(4, 1, 2'b10, 12, "inv_dis");

      // Async reset at counter=5 of a 10/8 waveform
      wr(2'd0, 32'd0);
      wr(2'd1, 32'd10);
      wr(2'd2, 32'd8);
      wr(2'd0, 32'd1);
      e = cyc;
      for (int k = 1; k <= 4; k++) expect_at(e + k, K_PWM, 32'd1, "prerst_pwm");
      expect_at(e + 5, K_PWM, 32'd0, "midrst_pwm");
      expect_at(e + 5, K_DONE, 32'd0, "midrst_done");
      idle_until(e + 5);
      iReset = 1'b1;
      repeat (2) @(posedge iClk);
      #1 iReset = 1'b0;
      e = cyc;
      for (int k = 0; k < 8; k++) begin
         expect_at(e + k, K_PWM, 32'd0, "postrst_pwm");
         expect_at(e + k, K_DONE, 32'd0, "postrst_done");
      end
      rd(2'd0, 32'd0, "postrst_ctrl");
      rd(2'd1, 32'd0, "postrst_period");
      rd(2'd2, 32'd0, "postrst_duty");
      rd(2'd3, 32'd0, "postrst_status");
      idle_until(e + 10);

      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
      $fatal(1, "watchdog expired");
   end
endmodule
